// File: rtl/seq_detect_ctrl.sv
// Programmable serial sequence detector with run control, saturating match counter
// and a sticky target-reached interrupt that holds the engine in DONE until acknowledged.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               stop,
    input  logic               X,
    input  logic               x_valid,
    input  logic               irq_ack,
    output logic               Y,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               irq,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_target;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [CNT_W-1:0]   r_count;
    logic               r_irq;

    logic [MAX_LEN:0]   w_window;
    logic [MAX_LEN:0]   w_mask;
    logic [LEN_W-1:0]   w_lenM1;
    logic [CNT_W-1:0]   w_countNext;
    logic [LEN_W-1:0]   w_fillNext;
    logic               w_cfgOk;
    logic               w_match;

    // The newest bit sits at window bit 0; the mask keeps only the low cfg_len bits.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i <= MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
        w_window    = {r_hist, X};
        w_lenM1     = r_len - LEN_W'(1);
        w_countNext = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);
        w_fillNext  = (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_W'(1);
        w_cfgOk     = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
        w_match     = (r_state == S_ARMED) && x_valid && !stop &&
                      (r_fill >= w_lenM1) &&
                      ((w_window & w_mask) == ({1'b0, r_pattern} & w_mask));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_len     <= LEN_MAX;
            r_overlap <= 1'b1;
            r_target  <= '0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_count   <= '0;
            r_irq     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_we && w_cfgOk) begin
                        r_pattern <= cfg_pattern;
                        r_len     <= cfg_len;
                        r_overlap <= cfg_overlap;
                        r_target  <= cfg_target;
                    end
                    if (start && !stop) begin
                        r_state <= S_ARMED;
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_count <= '0;
                    end
                end
                S_ARMED: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (x_valid) begin
                        r_hist <= w_window[MAX_LEN-1:0];
                        if (w_match) begin
                            r_count <= w_countNext;
                            r_fill  <= r_overlap ? w_fillNext : '0;
                            if ((r_target != '0) && (w_countNext == r_target)) begin
                                r_state <= S_DONE;
                                r_irq   <= 1'b1;
                            end
                        end else begin
                            r_fill <= w_fillNext;
                        end
                    end
                end
                S_DONE: begin
                    if (irq_ack || stop) begin
                        r_state <= S_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Y           = w_match;
    assign match_count = r_count;
    assign busy        = (r_state != S_IDLE);
    assign irq         = r_irq;
    assign state       = r_state;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: stimulus queues the expected Y per valid bit,
// a negedge monitor compares; a second instance with CNT_W=2 covers counter saturation.
module tb_seq_detect_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start;
    logic       stop;
    logic       X;
    logic       x_valid;
    logic       irq_ack;
    logic       Y;
    logic [7:0] match_count;
    logic       busy;
    logic       irq;
    logic [1:0] state;
    logic       y2;
    logic [1:0] count2;
    logic       busy2;
    logic       irq2;
    logic [1:0] state2;

    int checks;
    int failures;
    bit expQ[$];

    seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .start(start), .stop(stop), .X(X), .x_valid(x_valid), .irq_ack(irq_ack),
        .Y(Y), .match_count(match_count), .busy(busy), .irq(irq), .state(state)
    );

    seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target[1:0]),
        .start(start), .stop(stop), .X(X), .x_valid(x_valid), .irq_ack(irq_ack),
        .Y(y2), .match_count(count2), .busy(busy2), .irq(irq2), .state(state2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Y is combinational, so it is checked mid-cycle while the bit is still presented.
    always @(negedge clk) begin
        if (rst && x_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("y_unexpected", 1, 0);
            end else begin
                checkOutput("y_match", int'(Y), int'(expQ.pop_front()));
            end
        end
    end

    task automatic applyStimulus(input bit xBit, input bit valid, input bit stp, input bit expY);
        X = xBit;
        x_valid = valid;
        stop = stp;
        if (valid) expQ.push_back(expY);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        stop = 1'b0;
    endtask

    task automatic pulseStart(input bit stp);
        start = 1'b1;
        stop = stp;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic writeCfg(input logic [7:0] pat, input logic [3:0] len,
                            input bit ovl, input logic [7:0] tgt);
        cfg_we = 1'b1;
        cfg_pattern = pat;
        cfg_len = len;
        cfg_overlap = ovl;
        cfg_target = tgt;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic sendStream(input logic [7:0] bits, input logic [7:0] expY);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(bits[i], 1'b1, 1'b0, expY[i]);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_pattern = '0;
        cfg_len = '0;
        cfg_overlap = 1'b0;
        cfg_target = '0;
        start = 1'b0;
        stop = 1'b0;
        X = 1'b0;
        x_valid = 1'b0;
        irq_ack = 1'b0;

        #2 rst = 1'b0;
        #1;
        checkOutput("rst_state", int'(state), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_irq", int'(irq), 0);
        checkOutput("rst_count", int'(match_count), 0);
        checkOutput("rst_y", int'(Y), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Illegal length: defaults (len 8, pattern 0, overlap, no target) must remain.
        writeCfg(8'hFF, 4'd1, 1'b0, 8'd1);
        pulseStart(1'b0);
        checkOutput("arm_state", int'(state), 1);
        checkOutput("arm_busy", int'(busy), 1);
        sendStream(8'h00, 8'h01);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("default_count", int'(match_count), 2);
        checkOutput("default_state", int'(state), 1);

        // Asynchronous reset mid-ARMED.
        #3 rst = 1'b0;
        #1;
        checkOutput("midrst_state", int'(state), 0);
        checkOutput("midrst_count", int'(match_count), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Overlapping detection of 10110.
        writeCfg(8'b0001_0110, 4'd5, 1'b1, 8'd0);
        pulseStart(1'b0);
        sendStream(8'b1011_0110, 8'b0000_1001);
        checkOutput("ovl_count", int'(match_count), 2);
        checkOutput("ovl_state", int'(state), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("stop_state", int'(state), 0);
        checkOutput("stop_count_held", int'(match_count), 2);

        // Non-overlapping.
        writeCfg(8'b0001_0110, 4'd5, 1'b0, 8'd0);
        pulseStart(1'b0);
        sendStream(8'b1011_0110, 8'b0000_1000);
        checkOutput("novl_count", int'(match_count), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Target reached: DONE with irq, then frozen until acknowledged.
        writeCfg(8'b0001_0110, 4'd5, 1'b1, 8'd2);
        pulseStart(1'b0);
        sendStream(8'b1011_0110, 8'b0000_1001);
        checkOutput("done_state", int'(state), 2);
        checkOutput("done_irq", int'(irq), 1);
        checkOutput("done_busy", int'(busy), 1);
        checkOutput("done_count", int'(match_count), 2);
        sendStream(8'b1011_0110, 8'b0000_0000);
        checkOutput("done_count_frozen", int'(match_count), 2);
        checkOutput("done_irq_held", int'(irq), 1);
        irq_ack = 1'b1;
        @(posedge clk);
        #1;
        irq_ack = 1'b0;
        checkOutput("ack_state", int'(state), 0);
        checkOutput("ack_irq", int'(irq), 0);
        checkOutput("ack_count", int'(match_count), 2);

        // Qualifier gaps with X toggling, then stop coinciding with a match bit.
        writeCfg(8'b0001_0110, 4'd5, 1'b1, 8'd0);
        pulseStart(1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("qual_count", int'(match_count), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("stopmatch_state", int'(state), 0);
        checkOutput("stopmatch_count", int'(match_count), 1);

        // Five matches of "11": the 2-bit counter saturates at 3.
        writeCfg(8'b0000_0011, 4'd2, 1'b1, 8'd0);
        pulseStart(1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, (i != 0));
        end
        checkOutput("sat_count_wide", int'(match_count), 5);
        checkOutput("sat_count_narrow", int'(count2), 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // start together with stop in IDLE keeps the engine idle and the count intact.
        pulseStart(1'b1);
        checkOutput("collide_state", int'(state), 0);
        checkOutput("collide_busy", int'(busy), 0);
        checkOutput("collide_count", int'(match_count), 5);

        checkOutput("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Programmable, run-controlled serial sequence detector. Replaces the fixed single-pattern Mealy detector with a configurable engine.
- A host loads the pattern, length, overlap mode and match target while idle, then arms the engine. The engine checks a qualified serial bit stream and counts matches.
- When the target count is reached, the engine raises a sticky interrupt and holds until acknowledged.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (legal cfg_len range 2..MAX_LEN)
LEN_W, 4, width of cfg_len; must hold MAX_LEN
CNT_W, 8, width of match counter and target

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous active-low reset (asserts asynchronously on 0; deassertion is synchronised upstream)
cfg_we  input  1  config write strobe, accepted only in IDLE
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] = first received bit, bit [0] = last
cfg_len  input  LEN_W  pattern length
cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping
cfg_target  input  CNT_W  matches before DONE; 0 = run until stop
start  input  1  arm pulse, honoured in IDLE only
stop  input  1  abort to IDLE from ARMED or DONE
X  input  1  serial data bit
x_valid  input  1  X qualifier; X is ignored when 0
Y  output  1  Mealy match flag, combinational, same cycle as final bit
match_count  output  CNT_W  matches since last start, saturating
busy  output  1  1 in ARMED or DONE
irq  output  1  target reached; held until irq_ack
irq_ack  input  1  clears irq, DONE -> IDLE
state  output  2  IDLE=00, ARMED=01, DONE=10

Behaviour:
- Reset (rst=0): state=IDLE, pattern=0, len=MAX_LEN, overlap=1, target=0, history=0, fill=0, match_count=0, irq=0, busy=0, Y=0.
- Config: cfg_we in IDLE latches all cfg_* fields at the clock edge.
  - If cfg_len<2 or cfg_len>MAX_LEN, the whole write is ignored and the old config is kept.
  - cfg_we outside IDLE is ignored.
- History: MAX_LEN-bit shift register. On x_valid in ARMED, it shifts X in at bit 0.
- Fill: counts valid bits received since arm or since last clear, saturating at MAX_LEN.
- Match (combinational): in ARMED, with x_valid=1, stop=0, fill>=len-1, and {history[len-2:0],X} == pattern[len-1:0]. Y = match.
  - Y is 0 in all other cases, including IDLE and DONE.
- On match:
  - match_count increments, saturating at all-ones.
  - If overlap=0, fill clears to 0 (history contents are irrelevant after that).
  - If overlap=1, fill and history update normally.
- FSM transitions:
  - IDLE: start=1 and stop=0 -> ARMED. This clears history, fill and match_count and sets busy=1 next cycle.
  - IDLE: start and stop together -> stay IDLE.
  - ARMED: stop=1 -> IDLE; counters are retained and no match is counted.
  - ARMED: match with target!=0 and the post-increment count equal to target -> DONE, irq=1 next cycle.
  - ARMED: start is ignored.
  - DONE: X is ignored, history is frozen, Y=0. irq_ack=1 or stop=1 -> IDLE, irq=0 next cycle.
  - irq_ack in any other state has no effect.
- match_count is held in IDLE until the next start, so the host can read it.
- Latency: Y asserts in the same cycle as the last pattern bit. match_count, irq and state update on the following edge.
- Reset mid-operation forces all reset values immediately; configuration is lost.
- busy = (state != IDLE).

Test Plan:
- Reset/config: assert rst=0 mid-ARMED -> all outputs 0 and state=00 immediately. Write cfg_len=1 -> ignored, len stays 8. Write len=5, pattern=5'b10110 -> accepted.
- Overlap detect: overlap=1, target=0, start, then valid stream 1,0,1,1,0,1,1,0 -> Y=1 on bits 5 and 8; match_count=2; state stays ARMED.
- Non-overlap: same config with overlap=0, same stream -> Y=1 on bit 5 only; match_count=1.
- Target/irq: target=2, overlap=1, same stream -> DONE after bit 8, irq=1. Further matching bits give Y=0 and count=2. irq_ack -> IDLE, irq=0, count=2 retained.
- Qualifier/stop: insert x_valid=0 cycles with X toggling mid-pattern -> detection unaffected. Assert stop in the same cycle as a match bit -> Y=0, count unchanged, IDLE next cycle.
- Saturation and start/stop collision: CNT_W=2, target=0, five matches -> count sticks at 3. start+stop together in IDLE -> stays IDLE, busy=0.
